// File: rtl/maxnet_sequencer_pkg.sv
// Purpose : shared types and constants for the maxnet iteration sequencer.
// Latency : n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package maxnet_sequencer_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  // a-register source select values
  localparam logic A_SRC_INIT     = 1'b0;
  localparam logic A_SRC_FEEDBACK = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_LOAD_A,
    S_MULT,
    S_ADD,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_t;

  // Moore control outputs, one bundle per state
  typedef struct packed {
    logic start_ready;
    logic b_regs_en;
    logic a_regs_en;
    logic a_muxs;
    logic pu_mult_regs_en;
    logic pu_add_regs_en;
    logic done;
  } ctl_t;

  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_IDLE:   c.start_ready = 1'b1;
      S_LOAD_B: c.b_regs_en = 1'b1;
      S_LOAD_A: begin
        c.a_regs_en = 1'b1;
        c.a_muxs    = A_SRC_INIT;
      end
      S_MULT:   c.pu_mult_regs_en = 1'b1;
      S_ADD:    c.pu_add_regs_en = 1'b1;
      S_UPDATE: begin
        c.a_regs_en = 1'b1;
        c.a_muxs    = A_SRC_FEEDBACK;
      end
      S_DONE:   c.done = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/maxnet_lane_select.sv
// Purpose : classify the lane-zero flags: at most one nonzero lane, all lanes zero,
//           and the lowest nonzero lane index (0 when every lane is zero).
// Latency : combinational. Backpressure: none.
// Ports   : z[LANES-1:0] in (1 = lane is zero); nz_le1, nz_zero, low_idx out.
module maxnet_lane_select
  import maxnet_sequencer_pkg::*;
(
  input  logic [LANES-1:0]  z,
  output logic              nz_le1,
  output logic              nz_zero,
  output logic [LANE_W-1:0] low_idx
);

  logic [LANE_W:0] cnt;

  always_comb begin
    cnt     = '0;
    low_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + (LANE_W + 1)'(~z[i]);
    end
    // scan downwards so the lowest nonzero lane is the last one written
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!z[i]) low_idx = LANE_W'(i);
    end
    nz_le1  = (cnt <= (LANE_W + 1)'(1));
    nz_zero = (cnt == '0);
  end

endmodule

// File: rtl/maxnet_sequencer.sv
// Purpose : bounded, handshaked iteration sequencer for the 4-lane winner-take-all datapath.
// Latency : start at cycle 0 -> first CHECK at 3; +4 cycles per iteration; done 1 cycle after final CHECK.
// Backpressure: start accepted only in IDLE; DONE (and its result) held until res_ready.
// Ports   : start_valid/start_ready host handshake; z0..z3, end_signal datapath flags;
//           *_en, a_muxs datapath controls; res_mux, done/res_ready, iter_count, timeout, all_zero results.
module maxnet_sequencer
  import maxnet_sequencer_pkg::*;
#(
  parameter int MAX_ITER = 31,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              z0,
  input  logic              z1,
  input  logic              z2,
  input  logic              z3,
  input  logic              end_signal,
  output logic              b_regs_en,
  output logic              a_regs_en,
  output logic              a_muxs,
  output logic              pu_mult_regs_en,
  output logic              pu_add_regs_en,
  output logic [LANE_W-1:0] res_mux,
  output logic              done,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  iter_count,
  output logic              timeout,
  output logic              all_zero
);

  // iter_count must be able to reach MAX_ITER without wrapping
  generate
    if (MAX_ITER < 1 || MAX_ITER > (2 ** CNT_W) - 1) begin : g_bad_max_iter
      $error("maxnet_sequencer: MAX_ITER must be in 1..2**CNT_W-1");
    end
  endgenerate

  state_t            state;
  state_t            nxt;
  ctl_t              ctl;
  logic              nz_le1;
  logic              nz_zero;
  logic [LANE_W-1:0] low_idx;
  logic              resolved;

  maxnet_lane_select u_lane_select (
    .z       ({z3, z2, z1, z0}),
    .nz_le1  (nz_le1),
    .nz_zero (nz_zero),
    .low_idx (low_idx)
  );

  // end_signal wins even when the flags disagree
  assign resolved = end_signal | nz_le1;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start_valid) nxt = S_LOAD_B;
      S_LOAD_B: nxt = S_LOAD_A;
      S_LOAD_A: nxt = S_CHECK;
      S_MULT:   nxt = S_ADD;
      S_ADD:    nxt = S_UPDATE;
      S_UPDATE: nxt = S_CHECK;
      S_CHECK:  nxt = (resolved || iter_count == CNT_W'(MAX_ITER)) ? S_DONE : S_MULT;
      S_DONE:   if (res_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state, so they track the
  // state register exactly and never glitch on input changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ctl        <= ctl_for(S_IDLE);
      res_mux    <= '0;
      iter_count <= '0;
      timeout    <= 1'b0;
      all_zero   <= 1'b0;
    end else begin
      state <= nxt;
      ctl   <= ctl_for(nxt);
      if (state == S_IDLE && start_valid) begin
        iter_count <= '0;
        timeout    <= 1'b0;
        all_zero   <= 1'b0;
      end
      if (state == S_UPDATE) begin
        iter_count <= iter_count + CNT_W'(1);
      end
      if (state == S_CHECK && nxt == S_DONE) begin
        res_mux  <= low_idx;
        all_zero <= nz_zero;
        timeout  <= ~resolved;
      end
    end
  end

  assign start_ready     = ctl.start_ready;
  assign b_regs_en       = ctl.b_regs_en;
  assign a_regs_en       = ctl.a_regs_en;
  assign a_muxs          = ctl.a_muxs;
  assign pu_mult_regs_en = ctl.pu_mult_regs_en;
  assign pu_add_regs_en  = ctl.pu_add_regs_en;
  assign done            = ctl.done;

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Purpose : self-checking bench for maxnet_sequencer; two instances (MAX_ITER 31 and 2)
//           share stimulus and are compared each cycle against a run-timeline model.
// Latency/backpressure: n/a (bench).
module tb_maxnet_sequencer;

  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic res_ready = 1'b0;
  logic end_signal = 1'b0;
  logic [3:0] z = 4'b0000;

  logic [1:0] sr, ben, aen, amx, mul, add, dn, tmo, azr;
  logic [1:0][1:0] rm;
  logic [1:0][CNT_W-1:0] ic;

  always #5 clk = ~clk;

  maxnet_sequencer #(.MAX_ITER(31), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[0]),
    .z0(z[0]), .z1(z[1]), .z2(z[2]), .z3(z[3]), .end_signal(end_signal),
    .b_regs_en(ben[0]), .a_regs_en(aen[0]), .a_muxs(amx[0]),
    .pu_mult_regs_en(mul[0]), .pu_add_regs_en(add[0]), .res_mux(rm[0]),
    .done(dn[0]), .res_ready(res_ready), .iter_count(ic[0]),
    .timeout(tmo[0]), .all_zero(azr[0])
  );

  maxnet_sequencer #(.MAX_ITER(2), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[1]),
    .z0(z[0]), .z1(z[1]), .z2(z[2]), .z3(z[3]), .end_signal(end_signal),
    .b_regs_en(ben[1]), .a_regs_en(aen[1]), .a_muxs(amx[1]),
    .pu_mult_regs_en(mul[1]), .pu_add_regs_en(add[1]), .res_mux(rm[1]),
    .done(dn[1]), .res_ready(res_ready), .iter_count(ic[1]),
    .timeout(tmo[1]), .all_zero(azr[1])
  );

  // ---------------- behavioural model: run timeline by offset from accept ----------------
  bit         busy [2];
  bit         fin  [2];
  int         t0   [2];
  logic [1:0] m_res[2];
  bit         m_to [2];
  bit         m_az [2];
  int         m_iter[2];
  int         c = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] plan[$];
  bit         hold0 = 1'b0;

  function automatic int maxit(input int i);
    return (i == 0) ? 31 : 2;
  endfunction

  // index of the CHECK visit happening in cycle c, or -1
  function automatic int chk_idx(input int i);
    int off;
    if (!busy[i] || fin[i]) return -1;
    off = c - t0[i];
    if (off >= 3 && (off - 3) % 4 == 0) return (off - 3) / 4;
    return -1;
  endfunction

  function automatic logic [15:0] expv(input int i);
    logic s_r, b, a, mx, ml, ad, d;
    int off, r, it;
    s_r = !busy[i]; b = 0; a = 0; mx = 0; ml = 0; ad = 0; d = 0;
    it = m_iter[i];
    if (busy[i] && fin[i]) begin
      d = 1;
    end else if (busy[i]) begin
      off = c - t0[i];
      b = (off == 1);
      a = (off == 2);
      if (off >= 3) begin
        r  = (off - 3) % 4;
        it = (off - 3) / 4;
        ml = (r == 1);
        ad = (r == 2);
        if (r == 3) begin a = 1; mx = 1; end
      end
    end
    return {s_r, b, a, mx, ml, ad, d, m_to[i], m_az[i], m_res[i], 5'(it)};
  endfunction

  function automatic logic [15:0] actv(input int i);
    return {sr[i], ben[i], aen[i], amx[i], mul[i], add[i], dn[i], tmo[i], azr[i], rm[i], ic[i]};
  endfunction

  task automatic step_model();
    int j, nz;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 0; fin[i] = 0; m_res[i] = 0; m_to[i] = 0; m_az[i] = 0; m_iter[i] = 0;
      end else if (!busy[i]) begin
        if (start_valid) begin
          busy[i] = 1; fin[i] = 0; t0[i] = c; m_to[i] = 0; m_az[i] = 0; m_iter[i] = 0;
        end
      end else if (fin[i]) begin
        if (res_ready) begin busy[i] = 0; fin[i] = 0; end
      end else begin
        j = chk_idx(i);
        if (j >= 0) begin
          nz = 0;
          for (int l = 0; l < 4; l++) if (!z[l]) nz++;
          if (end_signal || nz <= 1 || j == maxit(i)) begin
            fin[i]    = 1;
            m_iter[i] = j;
            m_to[i]   = !(end_signal || nz <= 1);
            m_az[i]   = (nz == 0);
            m_res[i]  = 2'b00;
            for (int l = 3; l >= 0; l--) if (!z[l]) m_res[i] = 2'(l);
          end
        end
      end
    end
  endtask

  // one cycle: compare outputs of cycle c, drive inputs sampled at end of c, advance model
  task automatic cycle(input bit sv, input bit rr, input bit en, input bit r, input logic [3:0] zz);
    logic [15:0] e, a;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = expv(i);
      a = actv(i);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outs dut%0d cyc %0d: got %b want %b", i, c, a, e);
      end
    end
    start_valid = sv; res_ready = rr; end_signal = en; rst = r; z = zz;
    step_model();
    c++;
  endtask

  task automatic lit(input string nm, input int act, input int expd);
    n_cmp++;
    if (act != expd) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expd);
    end
  endtask

  function automatic logic [3:0] rz();
    logic [3:0] v;
    v = 4'($urandom);
    return ($urandom % 3 == 0) ? 4'b0000 : v;
  endfunction

  function automatic logic [3:0] zfor();
    int j;
    if (hold0) return 4'b0000;
    j = chk_idx(0);
    if (j >= 0) return (j < plan.size()) ? plan[j] : 4'b1110;
    return rz();
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 300 && (busy[0] || busy[1]); k++) cycle(0, 1, 0, 0, rz());
    if (busy[0] || busy[1]) lit("idle-wait expired", 0, 1);
  endtask

  // directed run on dut0's timeline; hold = cycles of res_ready low after done
  task automatic run_dir(input int hold, input int exp_res, output int doff,
                         output int nmul, output int nadd, output int nfb);
    int ta;
    bit seen;
    wait_idle();
    ta = c;
    cycle(1, 0, 0, 0, zfor());
    nmul = 0; nadd = 0; nfb = 0; seen = 0; doff = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      cycle(0, 0, 0, 0, zfor());
      if (mul[0]) nmul++;
      if (add[0]) nadd++;
      if (aen[0] && amx[0]) nfb++;
      if (dn[0]) begin seen = 1; doff = c - 1 - ta; end
    end
    if (!seen) lit("done-wait expired", 0, 1);
    for (int k = 0; k < hold; k++) begin
      cycle(($urandom % 2) == 1, 0, 0, 0, rz());
      lit("bp done held", int'(dn[0]), 1);
      lit("bp start_ready", int'(sr[0]), 0);
      lit("bp res_mux", int'(rm[0]), exp_res);
    end
    cycle(0, 1, 0, 0, rz());
    cycle(0, 0, 0, 0, rz());
    lit("start_ready after ack", int'(sr[0]), 1);
  endtask

  initial begin
    int doff, nm, na, nf, ta;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; fin[i] = 0; t0[i] = 0; m_res[i] = 0; m_to[i] = 0; m_az[i] = 0; m_iter[i] = 0;
    end
    cycle(0, 0, 0, 1, 4'b0000);
    cycle(0, 0, 0, 0, 4'b0000);
    lit("reset start_ready", int'(sr[0]), 1);
    lit("reset done", int'(dn[0]), 0);
    lit("reset iter_count", int'(ic[0]), 0);

    // resolved at load
    plan = '{4'b1110};
    run_dir(0, 0, doff, nm, na, nf);
    lit("resolved done offset", doff, 4);
    lit("resolved res_mux", int'(rm[0]), 0);
    lit("resolved iter_count", int'(ic[0]), 0);
    lit("resolved all_zero", int'(azr[0]), 0);
    lit("resolved timeout", int'(tmo[0]), 0);

    // three iterations
    plan = '{4'b0000, 4'b0010, 4'b0110, 4'b1101};
    run_dir(0, 1, doff, nm, na, nf);
    lit("iter3 mult pulses", nm, 3);
    lit("iter3 add pulses", na, 3);
    lit("iter3 feedback pulses", nf, 3);
    lit("iter3 done offset", doff, 16);
    lit("iter3 res_mux", int'(rm[0]), 1);
    lit("iter3 iter_count", int'(ic[0]), 3);
    lit("cap2 timeout", int'(tmo[1]), 1);
    lit("cap2 iter_count", int'(ic[1]), 2);

    // timeout: z held at 0000 on both instances
    hold0 = 1;
    run_dir(0, 0, doff, nm, na, nf);
    hold0 = 0;
    lit("cap31 done offset", doff, 128);
    lit("cap31 timeout", int'(tmo[0]), 1);
    lit("cap31 iter_count", int'(ic[0]), 31);
    lit("cap2 hold timeout", int'(tmo[1]), 1);
    lit("cap2 hold iter_count", int'(ic[1]), 2);
    lit("cap2 hold res_mux", int'(rm[1]), 0);

    // all zero at second CHECK
    plan = '{4'b0000, 4'b1111};
    run_dir(0, 0, doff, nm, na, nf);
    lit("allz all_zero", int'(azr[0]), 1);
    lit("allz res_mux", int'(rm[0]), 0);
    lit("allz timeout", int'(tmo[0]), 0);
    lit("allz iter_count", int'(ic[0]), 1);

    // backpressure in DONE
    plan = '{4'b1011};
    run_dir(5, 2, doff, nm, na, nf);
    lit("bp res_mux final", int'(rm[0]), 2);

    // reset during the first ADD
    wait_idle();
    ta = c;
    cycle(1, 0, 0, 0, 4'b0000);
    while (c <= ta + 5) cycle(0, 0, 0, c == ta + 5, 4'b0000);
    lit("rst in ADD", int'(add[0]), 1);
    cycle(0, 0, 0, 0, rz());
    lit("rst start_ready", int'(sr[0]), 1);
    lit("rst enables", int'({ben[0], aen[0], mul[0], add[0], dn[0]}), 0);
    plan = '{4'b1110};
    run_dir(0, 0, doff, nm, na, nf);
    lit("post-rst done offset", doff, 4);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom % 5 == 0, $urandom % 3 != 0, $urandom % 12 == 0, $urandom % 700 == 0, rz());
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
